matrix_aggregator: RTL and testbench
====================================

Name: matrix_aggregator

Overview:
- Collects the skewed, diagonal-wavefront output stream of a 4x4 systolic array and assembles it into a 4x4 register matrix of 32-bit words.
- Four input lanes d1..d4 deliver one element each per cycle, scheduled by an external step counter `count`.
- Each lane writes its elements along an L-shaped path: first along its own row, then down a column.
- The block sits between the systolic array drain and the consumer of the result matrix.

Parameters:
- DATA_W, 32, element width.
- CNT_W, 6, width of the step counter input.
- Array dimension N is fixed at 4 (package constant, not a parameter); the ports are named per cell.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- d1, d2, d3, d4  input  DATA_W  lane data; lane k is dk.
- count  input  CNT_W  wavefront step index, supplied by the controller.
- r11..r44 (16 ports, rIJ = row I, column J)  output  DATA_W  registered matrix cells.

Behaviour:
- One clock, one always block domain. rst is synchronous, active-high.
- On a rst edge, all 16 cells clear to 0. rst has priority over any capture in the same cycle.
- Capture happens on the rising edge using the values of count and dk sampled at that edge.
  - Result is visible on rIJ the cycle after the capture; latency is 1.
- Lane k (1..4) is active when k <= count <= 8-k:
  - lane 1: count 1..7
  - lane 2: count 2..6
  - lane 3: count 3..5
  - lane 4: count 4
- Step index s = count - k.
  - If s <= 4-k: the write target is (row k, col s+1).
  - Otherwise: the write target is (row k + s - (4-k), col 5-k).
- Resulting write schedule, as (count: cell) pairs:
  - lane 1: 1:r11, 2:r12, 3:r13, 4:r14, 5:r24, 6:r34, 7:r44
  - lane 2: 2:r21, 3:r22, 4:r23, 5:r33, 6:r43
  - lane 3: 3:r31, 4:r32, 5:r42
  - lane 4: 4:r41
- Lanes never target the same cell for a given count, so no write conflict exists.
- Outside a lane's active window (including count=0 and count>=8), that lane's input is ignored. Undriven or X data outside the window must not corrupt any cell.
- Cells not written in a cycle hold their value. The matrix persists after count passes 7 until overwritten or reset.
- count wrap-around (63 to 0) causes no writes. A new wavefront restarting at count=1 overwrites cells in the order above; there is no implicit clear.
- Reset mid-wavefront clears all cells. Later captures follow count normally; cells written earlier in that wave stay 0.

Optional Feature:
- Macro: MATRIX_AGGREGATOR_DONE_EN.
- When defined, add output `done` (1 bit, reset 0):
  - `done` is set registered in the cycle after the lane-1 capture at count=7, i.e. when r44 becomes valid.
  - `done` is cleared by rst, or by the capture at count=1 that starts a new wave.
  - It stays high otherwise.
- When undefined, the port and its logic are absent. Matrix behaviour is identical in both cases.

Decomposition:
- Package matrix_aggregator_pkg holds:
  - N=4, DATA_W, CNT_W constants;
  - the lane window bounds;
  - a function mapping (lane, count) to {valid, row, col}.
- One natural sub-module, matrix_aggregator_lane, instantiated 4 times with a LANE parameter.
  - It decodes count into a one-hot write enable over 16 cells.
- The top ORs the enables and muxes the lane data into the 16 cell registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles from power-up -> all r11..r44 = 0x00000000; with the optional feature, done=0.
- Full wavefront: count steps 1..7 with the lane schedule carrying values 0x0..0xF in row-major order.
  - Stimulus: lane 1 gets 0,1,2,3,7,b,f; lane 2 gets 4,5,6,a,e; lane 3 gets 8,9,d; lane 4 gets c.
  - Required response: one cycle after count=7, rIJ = 4(I-1)+(J-1), i.e. r11=0 ... r44=0xF; done=1 if enabled.
- Out-of-window immunity: after the full wave, drive count=0, 8, 63 with d1..d4=0xDEADBEEF -> matrix unchanged.
- Lane isolation: drive d4=0x1234 at count=3 -> no change. Then drive d4=0x1234 at count=4 with d1..d3 at their count=4 targets -> r41=0x1234, r14/r23/r32 take lanes 1..3, other cells unchanged.
- Reset mid-wave: rst=1 at count=4 -> all cells 0. Resume count=5..7 -> only r24, r34, r44, r33, r43, r42 are written; all others remain 0.
- Reset/capture priority: rst=1 and count=1 with d1=0xAAAA in the same cycle -> r11=0; a new wave at count=1 clears done.

Source files
------------

// File: rtl/matrix_aggregator_pkg.sv
// matrix_aggregator_pkg: array constants, lane window bounds and the (lane, count) -> cell mapping.
package matrix_aggregator_pkg;
  localparam int N = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W = 6;
  typedef struct packed {
    logic       valid;
    logic [1:0] row;
    logic [1:0] col;
  } cell_t;
  function automatic int lane_lo(input int lane);
    return lane;
  endfunction
  function automatic int lane_hi(input int lane);
    return 2 * N - lane;
  endfunction
  // Lane walks its own row first, then turns down column N+1-lane.
  function automatic cell_t lane_map(input int lane, input int cnt);
    cell_t m;
    int s;
    s = cnt - lane;
    m.valid = cnt >= lane_lo(lane) && cnt <= lane_hi(lane);
    m.row = s <= N - lane ? 2'(lane - 1) : 2'(lane - 1 + s - (N - lane));
    m.col = s <= N - lane ? 2'(s) : 2'(N - lane);
    return m;
  endfunction
endpackage

// File: rtl/matrix_aggregator_lane.sv
// matrix_aggregator_lane: decodes the step counter into a one-hot cell write enable for one lane.
module matrix_aggregator_lane #(
  parameter int LANE = 1,
  parameter int CNT_W = 6
) (
  input  logic [CNT_W-1:0] count,
  output logic [15:0]      we_o
);
  import matrix_aggregator_pkg::*;
  cell_t m;
  always_comb begin
    m = lane_map(LANE, int'(count));
    we_o = m.valid ? 16'(1) << {m.row, m.col} : '0;
  end
endmodule

// File: rtl/matrix_aggregator.sv
// matrix_aggregator: assembles the skewed 4-lane systolic drain into a registered 4x4 matrix.
// Optional MATRIX_AGGREGATOR_DONE_EN adds a done flag raised once r44 is valid.
module matrix_aggregator #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  input  logic [DATA_W-1:0] d4,
  input  logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] r11,
  output logic [DATA_W-1:0] r12,
  output logic [DATA_W-1:0] r13,
  output logic [DATA_W-1:0] r14,
  output logic [DATA_W-1:0] r21,
  output logic [DATA_W-1:0] r22,
  output logic [DATA_W-1:0] r23,
  output logic [DATA_W-1:0] r24,
  output logic [DATA_W-1:0] r31,
  output logic [DATA_W-1:0] r32,
  output logic [DATA_W-1:0] r33,
  output logic [DATA_W-1:0] r34,
  output logic [DATA_W-1:0] r41,
  output logic [DATA_W-1:0] r42,
  output logic [DATA_W-1:0] r43,
  output logic [DATA_W-1:0] r44
`ifdef MATRIX_AGGREGATOR_DONE_EN
  , output logic            done
`endif
);
  import matrix_aggregator_pkg::*;
  logic [15:0]       we [N];
  logic [DATA_W-1:0] cell_q [N*N];
  logic [DATA_W-1:0] cell_d [N*N];
  for (genvar g = 0; g < N; g++) begin : g_lane
    matrix_aggregator_lane #(.LANE(g + 1), .CNT_W(CNT_W)) u_lane (.count(count), .we_o(we[g]));
  end
  // Lanes never collide on a cell, so the priority order of this mux is irrelevant.
  always_comb begin
    for (int i = 0; i < N * N; i++)
      cell_d[i] = we[0][i] ? d1 : we[1][i] ? d2 : we[2][i] ? d3 : we[3][i] ? d4 : cell_q[i];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < N * N; i++)
      cell_q[i] <= rst ? '0 : cell_d[i];
  end
  assign r11 = cell_q[0];
  assign r12 = cell_q[1];
  assign r13 = cell_q[2];
  assign r14 = cell_q[3];
  assign r21 = cell_q[4];
  assign r22 = cell_q[5];
  assign r23 = cell_q[6];
  assign r24 = cell_q[7];
  assign r31 = cell_q[8];
  assign r32 = cell_q[9];
  assign r33 = cell_q[10];
  assign r34 = cell_q[11];
  assign r41 = cell_q[12];
  assign r42 = cell_q[13];
  assign r43 = cell_q[14];
  assign r44 = cell_q[15];
`ifdef MATRIX_AGGREGATOR_DONE_EN
  logic done_q;
  logic done_d;
  always_comb done_d = count == CNT_W'(1) ? 1'b0 : count == CNT_W'(7) ? 1'b1 : done_q;
  always_ff @(posedge clk) done_q <= rst ? 1'b0 : done_d;
  assign done = done_q;
`endif
endmodule

// File: tb/tb_matrix_aggregator.sv
// tb_matrix_aggregator: directed-vector bench for matrix_aggregator with hand-computed expectations.
module tb_matrix_aggregator;
  logic        clk = 0;
  logic        rst;
  logic [31:0] d [4];
  logic [5:0]  cnt;
  logic [31:0] r [16];
  logic [31:0] ex [16];
  int total = 0;
  int bad = 0;
`ifdef MATRIX_AGGREGATOR_DONE_EN
  logic done;
`endif
  always #5 clk = ~clk;
  matrix_aggregator dut (
    .clk(clk), .rst(rst), .d1(d[0]), .d2(d[1]), .d3(d[2]), .d4(d[3]), .count(cnt),
    .r11(r[0]), .r12(r[1]), .r13(r[2]), .r14(r[3]),
    .r21(r[4]), .r22(r[5]), .r23(r[6]), .r24(r[7]),
    .r31(r[8]), .r32(r[9]), .r33(r[10]), .r34(r[11]),
    .r41(r[12]), .r42(r[13]), .r43(r[14]), .r44(r[15])
`ifdef MATRIX_AGGREGATOR_DONE_EN
    , .done(done)
`endif
  );
  task automatic step(input logic rs, input logic [5:0] c,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e, input logic [31:0] f);
    @(negedge clk);
    rst = rs; cnt = c; d[0] = a; d[1] = b; d[2] = e; d[3] = f;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask
  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_r%0d%0d", tag, i / 4 + 1, i % 4 + 1), r[i], ex[i]);
  endtask
  task automatic check_done(input string tag, input logic want);
`ifdef MATRIX_AGGREGATOR_DONE_EN
    chk(tag, {31'd0, done}, {31'd0, want});
`else
    if (want === 1'bx) $display("unused %s", tag);
`endif
  endtask
  localparam logic [31:0] X = 32'hxxxxxxxx;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  initial begin
    // Reset from power-up.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) ex[i] = 0;
    check_all("reset");
    check_done("reset_done", 0);
    // Full wavefront, out-of-window lanes driven with X.
    step(0, 1, 32'h0, X, X, X);
    step(0, 2, 32'h1, 32'h4, X, X);
    step(0, 3, 32'h2, 32'h5, 32'h8, X);
    step(0, 4, 32'h3, 32'h6, 32'h9, 32'hc);
    step(0, 5, 32'h7, 32'ha, 32'hd, X);
    step(0, 6, 32'hb, 32'he, X, X);
    check_done("done_before_7", 0);
    step(0, 7, 32'hf, X, X, X);
    for (int i = 0; i < 16; i++) ex[i] = i;
    check_all("wave");
    check_done("wave_done", 1);
    // Out-of-window immunity.
    step(0, 0, DB, DB, DB, DB);
    step(0, 8, DB, DB, DB, DB);
    step(0, 63, DB, DB, DB, DB);
    check_all("oow");
    check_done("oow_done", 1);
    // Lane 4 ignored at count 3; lanes 1..3 rewrite their current values.
    step(0, 3, 32'h2, 32'h5, 32'h8, 32'h1234);
    check_all("iso3");
    step(0, 4, 32'h100, 32'h200, 32'h300, 32'h1234);
    ex[3] = 32'h100; ex[6] = 32'h200; ex[9] = 32'h300; ex[12] = 32'h1234;
    check_all("iso4");
    // Reset mid-wave, then resume at count 5.
    step(1, 4, 32'h41, 32'h42, 32'h43, 32'h44);
    for (int i = 0; i < 16; i++) ex[i] = 0;
    check_all("midrst");
    check_done("midrst_done", 0);
    step(0, 5, 32'h51, 32'h52, 32'h53, X);
    step(0, 6, 32'h61, 32'h62, X, X);
    step(0, 7, 32'h71, X, X, X);
    ex[7] = 32'h51; ex[10] = 32'h52; ex[13] = 32'h53;
    ex[11] = 32'h61; ex[14] = 32'h62; ex[15] = 32'h71;
    check_all("resume");
    check_done("resume_done", 1);
    // Reset wins over a count=1 capture.
    step(1, 1, 32'hAAAA, X, X, X);
    for (int i = 0; i < 16; i++) ex[i] = 0;
    check_all("prio");
    check_done("prio_done", 0);
    step(0, 7, 32'h77, X, X, X);
    ex[15] = 32'h77;
    check_all("r44_only");
    check_done("set_done", 1);
    // New wave at count=1 clears done without clearing the matrix.
    step(0, 1, 32'h11, X, X, X);
    ex[0] = 32'h11;
    check_all("newwave");
    check_done("newwave_done", 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
